// File: rtl/backward_recursion_module.sv
// backward_recursion_module: batch-reversing complex first-order recursion y = x + factorR*y_prev
module backward_recursion_module #(
  parameter int          DEPTH   = 64,
  parameter logic [31:0] factorR = 32'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] resetVal,
  output logic [31:0] out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  typedef enum logic {FILL, DRAIN} state_t;
  state_t state, state_n;
  logic [31:0] mem [2**AW];
  logic [AW-1:0] idx, idx_n;
  logic [31:0] x, y, nxt;
  logic signed [32:0] pr, pi;
  logic acc, dh, ld, last_n;
  assign in_ready  = state == FILL;
  assign out_valid = state == DRAIN;
  always_comb begin
    acc = in_valid && in_ready;
    dh = out_valid && out_ready;
    x = in_ready ? in : mem[idx];
    y = in_ready ? resetVal : out;
    pr = $signed(factorR[31:16]) * $signed(y[31:16]) - $signed(factorR[15:0]) * $signed(y[15:0]);
    pi = $signed(factorR[31:16]) * $signed(y[15:0]) + $signed(factorR[15:0]) * $signed(y[31:16]);
    nxt = {x[31:16] + 16'(pr >>> 15), x[15:0] + 16'(pi >>> 15)};
    ld = (acc && idx == LAST) || (dh && !out_last);
    state_n = state;
    idx_n = idx;
    last_n = out_last;
    if (acc) begin
      state_n = idx == LAST ? DRAIN : FILL;
      idx_n = idx == LAST ? AW'(DEPTH - 2) : idx + AW'(1);
    end
    if (dh) begin
      state_n = out_last ? FILL : DRAIN;
      idx_n = out_last ? '0 : idx - AW'(1);
      last_n = !out_last && idx == '0;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= FILL;
      idx <= '0;
      out <= '0;
      out_last <= 1'b0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      out_last <= last_n;
      if (ld) out <= nxt;
    end
  always_ff @(posedge clk)
    if (acc) mem[idx] <= in;
endmodule

// File: tb/tb_backward_recursion_module.sv
// tb_backward_recursion_module: directed vectors over four parameterisations of the backward recursion
module tb_backward_recursion_module;
  localparam int DEP [4] = '{4, 4, 3, 2};
  localparam logic [31:0] FR [4] = '{32'h0000_0000, 32'h4000_0000, 32'h0000_4000, 32'h4000_0000};
  typedef struct {
    int k;
    int n;
    logic [31:0] seed;
    logic [3:0][31:0] x;
    logic [3:0][31:0] y;
    int stall;
    bit pulse;
  } vec_t;
  logic clk = 1'b0;
  logic [3:0] rst, iv, ir, ov, ordy, ol;
  logic [3:0][31:0] din, rv, dout;
  int tests = 0, fails = 0;
  vec_t v [5];
  always #5 clk = ~clk;
  for (genvar g = 0; g < 4; g++) begin : u
    backward_recursion_module #(.DEPTH(DEP[g]), .factorR(FR[g])) dut (
      .clk(clk), .rst(rst[g]), .in(din[g]), .in_valid(iv[g]), .in_ready(ir[g]),
      .resetVal(rv[g]), .out(dout[g]), .out_valid(ov[g]), .out_ready(ordy[g]), .out_last(ol[g])
    );
  end
  task automatic chk(input string nm, input logic [33:0] act, input logic [33:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  function automatic logic [33:0] st(input int k);
    return {ov[k], ol[k], dout[k]};
  endfunction
  task automatic run(input vec_t t);
    int k = t.k;
    for (int i = 0; i < t.n; i++) begin
      @(negedge clk);
      chk($sformatf("k%0d in_ready fill %0d", k, i), {33'b0, ir[k]}, 34'd1);
      din[k] = t.x[i];
      rv[k] = t.seed;
      iv[k] = 1'b1;
    end
    @(negedge clk);
    iv[k] = 1'b0;
    din[k] = '0;
    rv[k] = 32'hDEAD_BEEF;
    ordy[k] = 1'b1;
    for (int i = 0; i < t.n; i++) begin
      chk($sformatf("k%0d out %0d", k, i), st(k), {1'b1, i == t.n - 1, t.y[i]});
      if (t.pulse) begin
        chk($sformatf("k%0d in_ready drain %0d", k, i), {33'b0, ir[k]}, 34'd0);
        iv[k] = (i % 2 == 0);
        din[k] = 32'h1234_5678;
      end
      if (i == t.stall) begin
        ordy[k] = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk($sformatf("k%0d stall hold %0d", k, i), st(k), {1'b1, i == t.n - 1, t.y[i]});
        end
        ordy[k] = 1'b1;
      end
      @(negedge clk);
    end
    iv[k] = 1'b0;
    ordy[k] = 1'b0;
    chk($sformatf("k%0d turnaround", k), {32'b0, ov[k], ir[k]}, 34'd1);
  endtask
  initial begin
    v[0] = '{0, 4, 32'h0,
             {32'h0400_0000, 32'h0300_0000, 32'h0200_0000, 32'h0100_0000},
             {32'h0100_0000, 32'h0200_0000, 32'h0300_0000, 32'h0400_0000}, -1, 1'b0};
    v[1] = '{1, 4, 32'h0,
             {4{32'h2000_0000}},
             {32'h3C00_0000, 32'h3800_0000, 32'h3000_0000, 32'h2000_0000}, -1, 1'b0};
    v[2] = '{2, 3, 32'h0,
             {32'h0, 32'h4000_0000, 32'h4000_0000, 32'h4000_0000},
             {32'h0, 32'h3000_2000, 32'h4000_2000, 32'h4000_0000}, -1, 1'b0};
    v[3] = '{3, 2, 32'h7000_0000,
             {32'h0, 32'h0, 32'h7000_0000, 32'h7000_0000},
             {32'h0, 32'h0, 32'h4400_0000, 32'hA800_0000}, -1, 1'b0};
    v[4] = v[1];
    v[4].stall = 1;
    v[4].pulse = 1'b1;
    rst = '1;
    iv = '0;
    ordy = '0;
    din = '0;
    rv = '0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 4; k++)
      chk($sformatf("k%0d reset state", k), {ov[k], ol[k], dout[k]} ^ {1'b0, ir[k], 32'b0}, 34'h1_0000_0000 ^ 34'h1_0000_0000 ^ {1'b0, 1'b1, 32'b0});
    rst = '0;
    @(negedge clk);
    for (int k = 0; k < 4; k++)
      chk($sformatf("k%0d post-release", k), {ov[k], ol[k], ir[k], dout[k][30:0]}, {3'b001, 31'b0});
    for (int i = 0; i < 5; i++) run(v[i]);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      din[1] = 32'h2000_0000;
      rv[1] = 32'h0;
      iv[1] = 1'b1;
    end
    @(negedge clk);
    iv[1] = 1'b0;
    ordy[1] = 1'b1;
    repeat (2) @(negedge clk);
    ordy[1] = 1'b0;
    chk("k1 before reset", st(1), {2'b10, 32'h3800_0000});
    #2 rst[1] = 1'b1;
    #1 chk("k1 async reset", {ov[1], ol[1], ir[1], dout[1][30:0]}, {3'b001, 31'b0});
    chk("k1 async reset out", {2'b0, dout[1]}, 34'd0);
    @(negedge clk);
    rst[1] = 1'b0;
    run(v[1]);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
